// File: rtl/dsp_result_fifo.sv
// Result FIFO behind the DSP datapath: captures {dspcontrol tag, dspout} per push and
// releases them over a show-ahead valid/ready stream. Optional peak tracker: DSP_RESULT_PEAK_EN.
module dsp_result_fifo #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [TAG_W-1:0]  wr_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              clr_ovf
`ifdef DSP_RESULT_PEAK_EN
  ,
  output logic [DATA_W-1:0] peak_abs,
  input  logic              peak_clr
`endif
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [TAG_W-1:0]  mem_tag  [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [DATA_W-1:0] last_data;
  logic [TAG_W-1:0]  last_tag;
  logic              pop;
  logic              push;
  logic              drop;

  always_comb begin
    empty     = (count == '0);
    full      = (count == FULL_CNT);
    out_valid = !empty;
    pop       = out_valid && out_ready;
    push      = wr_en && (!full || pop);
    drop      = wr_en && full && !pop;
    // While empty, replay the last head so the outputs hold rather than expose stale slots.
    if (empty) begin
      out_data = last_data;
      out_tag  = last_tag;
    end else begin
      out_data = mem_data[rd_ptr];
      out_tag  = mem_tag[rd_ptr];
    end
  end

  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem_data[wr_ptr] <= wr_data;
      mem_tag[wr_ptr]  <= wr_tag;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      last_data <= '0;
      last_tag  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      if (push && !pop)      count <= count + (ADDR_W+1)'(1);
      else if (pop && !push) count <= count - (ADDR_W+1)'(1);
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
      if (!empty) begin
        last_data <= mem_data[rd_ptr];
        last_tag  <= mem_tag[rd_ptr];
      end
    end
  end

`ifdef DSP_RESULT_PEAK_EN
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

  logic [DATA_W-1:0] wr_abs;

  always_comb begin
    if (!wr_data[DATA_W-1])      wr_abs = wr_data;
    else if (wr_data == MOST_NEG) wr_abs = MOST_POS;
    else                          wr_abs = -wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      peak_abs <= '0;
    end else if (peak_clr) begin
      peak_abs <= push ? wr_abs : '0;
    end else if (push && (wr_abs > peak_abs)) begin
      peak_abs <= wr_abs;
    end
  end
`endif

endmodule

// File: tb/tb_dsp_result_fifo.sv
// Self-checking bench for dsp_result_fifo: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations. Define DSP_RESULT_PEAK_EN to cover the peak tracker.
module tb_dsp_result_fifo;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 5;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [TAG_W-1:0]  wr_tag = '0;
  logic              out_ready = 1'b0;
  logic              clr_ovf = 1'b0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              overflow;
`ifdef DSP_RESULT_PEAK_EN
  logic [DATA_W-1:0] peak_abs;
  logic              peak_clr = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  dsp_result_fifo #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_tag(wr_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .count(count), .full(full), .empty(empty), .overflow(overflow), .clr_ovf(clr_ovf)
`ifdef DSP_RESULT_PEAK_EN
    , .peak_abs(peak_abs), .peak_clr(peak_clr)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: entries are {tag, data}
  logic [TAG_W+DATA_W-1:0] q[$];
  logic [TAG_W+DATA_W-1:0] m_last = '0;
  logic                    m_ovf = 1'b0;
  logic [DATA_W-1:0]       m_peak = '0;

  function automatic logic [DATA_W-1:0] sat_abs(input logic [DATA_W-1:0] v);
    if ($signed(v) >= 0) return v;
    if (v == 32'h8000_0000) return 32'h7FFF_FFFF;
    return 32'(-$signed(v));
  endfunction

  always @(posedge clk) begin
    bit pop_m, push_m, drop_m;
    logic pk_clr;
`ifdef DSP_RESULT_PEAK_EN
    pk_clr = peak_clr;
`else
    pk_clr = 1'b0;
`endif
    if (reset) begin
      q.delete();
      m_last = '0;
      m_ovf  = 1'b0;
      m_peak = '0;
    end else begin
      pop_m  = out_ready && (q.size() != 0);
      push_m = wr_en && ((q.size() < DEPTH) || pop_m);
      drop_m = wr_en && !push_m;
      if (q.size() != 0) m_last = q[0];
      if (pop_m) void'(q.pop_front());
      if (push_m) q.push_back({wr_tag, wr_data});
      if (drop_m) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      if (pk_clr) m_peak = push_m ? sat_abs(wr_data) : '0;
      else if (push_m && sat_abs(wr_data) > m_peak) m_peak = sat_abs(wr_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("count", 64'(count), 64'(q.size()));
      check("out_valid", 64'(out_valid), 64'(q.size() != 0));
      check("empty", 64'(empty), 64'(q.size() == 0));
      check("full", 64'(full), 64'(q.size() == DEPTH));
      check("overflow", 64'(overflow), 64'(m_ovf));
      if (q.size() != 0) check("head", 64'({out_tag, out_data}), 64'(q[0]));
      else               check("hold", 64'({out_tag, out_data}), 64'(m_last));
`ifdef DSP_RESULT_PEAK_EN
      check("peak_abs", 64'(peak_abs), 64'(m_peak));
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset then idle
    reset = 1'b1;
    cyc();
    chk_en = 1;
    cyc();
    reset = 1'b0;
    cyc();
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);

    // Single push, 1-cycle first-word latency
    wr_en = 1'b1; wr_data = 32'h11; wr_tag = 5'b00010;
    #1 check("first_valid_push_cycle", 64'(out_valid), 64'd0);
    cyc();
    wr_en = 1'b0;
    check("first_valid", 64'(out_valid), 64'd1);
    check("first_data", 64'(out_data), 64'h11);
    check("first_tag", 64'(out_tag), 64'd2);
    check("first_count", 64'(count), 64'd1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("hold_after_drain", 64'(out_data), 64'h11);

    // Fill 1..8, overflow on 9, drain in order, clear overflow
    wr_en = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      wr_data = 32'(i); wr_tag = 5'(i);
      cyc();
    end
    wr_en = 1'b0;
    check("fill_full", 64'(full), 64'd1);
    check("fill_count", 64'(count), 64'd8);
    check("fill_ovf", 64'(overflow), 64'd1);
    for (int i = 1; i <= 8; i++) begin
      check("drain_order", 64'(out_data), 64'(i));
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
    end
    check("drain_empty", 64'(empty), 64'd1);
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    check("ovf_cleared", 64'(overflow), 64'd0);

    // Full with simultaneous push and pop
    wr_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      wr_data = 32'h100 + 32'(i);
      cyc();
    end
    wr_data = 32'hAA; out_ready = 1'b1;
    cyc();
    wr_en = 1'b0;
    check("pp_count", 64'(count), 64'd8);
    check("pp_ovf", 64'(overflow), 64'd0);
    check("pp_head", 64'(out_data), 64'h102);
    repeat (7) cyc();
    check("pp_aa_head", 64'(out_data), 64'hAA);
    check("pp_aa_count", 64'(count), 64'd1);
    cyc();
    out_ready = 1'b0;
    check("pp_empty", 64'(empty), 64'd1);

    // Streaming with out_ready held high; pointers wrap
    wr_en = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wr_data = 32'h200 + 32'(k);
      cyc();
      check("stream_head", 64'(out_data), 64'h200 + 64'(k));
      check("stream_count", 64'(count), 64'd1);
    end
    wr_en = 1'b0;
    cyc();
    out_ready = 1'b0;
    check("stream_empty", 64'(empty), 64'd1);

`ifdef DSP_RESULT_PEAK_EN
    begin
      logic [DATA_W-1:0] pv[4];
      logic [DATA_W-1:0] pe[4];
      pv = '{32'd5, 32'hFFFF_FFF4, 32'h8000_0000, 32'd3};
      pe = '{32'd5, 32'd12, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
      reset = 1'b1; cyc(); reset = 1'b0;
      wr_en = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        wr_data = pv[i];
        cyc();
        check("peak_seq", 64'(peak_abs), 64'(pe[i]));
      end
      peak_clr = 1'b1; wr_data = 32'hFFFF_FFFC;
      cyc();
      peak_clr = 1'b0; wr_en = 1'b0;
      check("peak_clr_push", 64'(peak_abs), 64'd4);
      cyc();
      out_ready = 1'b0;
    end
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 299) == 0);
      wr_en     = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 50);
      clr_ovf   = ($urandom_range(0, 99) < 3);
      wr_data   = $urandom;
      wr_tag    = 5'($urandom);
`ifdef DSP_RESULT_PEAK_EN
      peak_clr  = ($urandom_range(0, 99) < 2);
`endif
      cyc();
    end
    reset = 1'b0; wr_en = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
